// File: rtl/mac_rx_pkt_queue.sv
// Receive-side frame queue: buffers beats, exposes only complete frames, drops frames on overflow.
// Optional drop counter output enabled by defining MAC_RX_PKT_QUEUE_DROP_CNT_EN.
module mac_rx_pkt_queue #(
  parameter int DATA_W       = 512,
  parameter int PADBYTES_W   = 6,
  parameter int FRAME_SIZE_W = 16,
  parameter int LOG2_ELS     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    src_val,
  input  logic [DATA_W-1:0]       src_data,
  input  logic                    src_last,
  input  logic [PADBYTES_W-1:0]   src_padbytes,
  output logic                    src_rdy,
  output logic                    dst_val,
  output logic [DATA_W-1:0]       dst_data,
  output logic                    dst_startframe,
  output logic                    dst_endframe,
  output logic [PADBYTES_W-1:0]   dst_padbytes,
  output logic [FRAME_SIZE_W-1:0] dst_frame_size,
  input  logic                    dst_rdy
`ifdef MAC_RX_PKT_QUEUE_DROP_CNT_EN
  ,
  output logic [31:0]             drop_cnt
`endif
);

  localparam int DEPTH = 1 << LOG2_ELS;
  localparam int PTR_W = LOG2_ELS + 1;
  localparam int BYTES = DATA_W / 8;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] rd_q, rd_d, cm_q, cm_d, wr_q, wr_d;
  logic [PTR_W-1:0] sz_rd_q, sz_rd_d, sz_wr_q, sz_wr_d;
  logic             in_frame_q, in_frame_d;
  logic             drop_q, drop_d;

  logic [DATA_W-1:0]       data_mem [DEPTH];
  logic                    sf_mem   [DEPTH];
  logic                    ef_mem   [DEPTH];
  logic [PADBYTES_W-1:0]   pad_mem  [DEPTH];
  logic [FRAME_SIZE_W-1:0] size_mem [DEPTH];

  logic                    rd_fire_s, sz_pop_s;
  logic                    beat_full_s, size_full_s;
  logic                    accept_s, ovf_s, wr_en_s, commit_s;
  logic [FRAME_SIZE_W-1:0] size_s;

  assign src_rdy = 1'b1;

  assign dst_val        = (rd_q != cm_q);
  assign dst_data       = data_mem[rd_q[LOG2_ELS-1:0]];
  assign dst_startframe = dst_val & sf_mem[rd_q[LOG2_ELS-1:0]];
  assign dst_endframe   = dst_val & ef_mem[rd_q[LOG2_ELS-1:0]];
  assign dst_padbytes   = pad_mem[rd_q[LOG2_ELS-1:0]];
  assign dst_frame_size = dst_val ? size_mem[sz_rd_q[LOG2_ELS-1:0]] : {FRAME_SIZE_W{1'b0}};

  assign rd_fire_s = dst_val & dst_rdy;
  assign sz_pop_s  = rd_fire_s & dst_startframe;

  // A read in the same cycle frees a slot for the incoming beat or size.
  assign beat_full_s = ((wr_q - rd_q) == DEPTH_P) & ~rd_fire_s;
  assign size_full_s = ((sz_wr_q - sz_rd_q) == DEPTH_P) & ~sz_pop_s;

  assign accept_s = src_val & ~drop_q;
  assign ovf_s    = accept_s & (beat_full_s | (src_last & size_full_s));
  assign wr_en_s  = accept_s & ~ovf_s;
  assign commit_s = wr_en_s & src_last;

  assign size_s = FRAME_SIZE_W'(32'(wr_q - cm_q + ONE_P) * 32'(BYTES) - 32'(src_padbytes));

  // Next-state for pointers, in-frame and drop flags.
  always_comb begin
    rd_d       = rd_q;
    cm_d       = cm_q;
    wr_d       = wr_q;
    sz_rd_d    = sz_rd_q;
    sz_wr_d    = sz_wr_q;
    in_frame_d = in_frame_q;
    drop_d     = drop_q;
    if (rd_fire_s) begin
      rd_d = rd_q + ONE_P;
    end else begin
      rd_d = rd_q;
    end
    if (sz_pop_s) begin
      sz_rd_d = sz_rd_q + ONE_P;
    end else begin
      sz_rd_d = sz_rd_q;
    end
    if (ovf_s) begin
      wr_d = cm_q;
    end else if (wr_en_s) begin
      wr_d = wr_q + ONE_P;
    end else begin
      wr_d = wr_q;
    end
    if (commit_s) begin
      cm_d    = wr_q + ONE_P;
      sz_wr_d = sz_wr_q + ONE_P;
    end else begin
      cm_d    = cm_q;
      sz_wr_d = sz_wr_q;
    end
    if (src_val) begin
      in_frame_d = ~src_last;
      drop_d     = (drop_q | ovf_s) & ~src_last;
    end else begin
      in_frame_d = in_frame_q;
      drop_d     = drop_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= {PTR_W{1'b0}};
      cm_q       <= {PTR_W{1'b0}};
      wr_q       <= {PTR_W{1'b0}};
      sz_rd_q    <= {PTR_W{1'b0}};
      sz_wr_q    <= {PTR_W{1'b0}};
      in_frame_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      cm_q       <= cm_d;
      wr_q       <= wr_d;
      sz_rd_q    <= sz_rd_d;
      sz_wr_q    <= sz_wr_d;
      in_frame_q <= in_frame_d;
      drop_q     <= drop_d;
    end
  end

  // Beat and size storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      data_mem[wr_q[LOG2_ELS-1:0]] <= src_data;
      sf_mem[wr_q[LOG2_ELS-1:0]]   <= ~in_frame_q;
      ef_mem[wr_q[LOG2_ELS-1:0]]   <= src_last;
      pad_mem[wr_q[LOG2_ELS-1:0]]  <= src_padbytes;
    end
    if (commit_s) begin
      size_mem[sz_wr_q[LOG2_ELS-1:0]] <= size_s;
    end
  end

`ifdef MAC_RX_PKT_QUEUE_DROP_CNT_EN
  logic [31:0] drop_cnt_q;

  // Count each dropped frame once, at the beat that triggers the overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 32'd0;
    end else if (ovf_s) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end else begin
      drop_cnt_q <= drop_cnt_q;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mac_rx_pkt_queue.sv
// Scoreboard bench for mac_rx_pkt_queue: stimulus pushes expected beats, a monitor pops on each transfer.
module tb_mac_rx_pkt_queue;

  logic         clk;
  logic         rst;
  logic         src_val;
  logic [511:0] src_data;
  logic         src_last;
  logic [5:0]   src_padbytes;
  logic         src_rdy;
  logic         dst_val;
  logic [511:0] dst_data;
  logic         dst_startframe;
  logic         dst_endframe;
  logic [5:0]   dst_padbytes;
  logic [15:0]  dst_frame_size;
  logic         dst_rdy;
`ifdef MAC_RX_PKT_QUEUE_DROP_CNT_EN
  logic [31:0]  drop_cnt;
`endif

  mac_rx_pkt_queue dut (
    .clk            (clk),
    .rst            (rst),
    .src_val        (src_val),
    .src_data       (src_data),
    .src_last       (src_last),
    .src_padbytes   (src_padbytes),
    .src_rdy        (src_rdy),
    .dst_val        (dst_val),
    .dst_data       (dst_data),
    .dst_startframe (dst_startframe),
    .dst_endframe   (dst_endframe),
    .dst_padbytes   (dst_padbytes),
    .dst_frame_size (dst_frame_size),
    .dst_rdy        (dst_rdy)
`ifdef MAC_RX_PKT_QUEUE_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  typedef struct {
    logic [511:0] data;
    logic         sf;
    logic         ef;
    logic [5:0]   pad;
    logic [15:0]  size;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   out_cnt = 0;
  int   fid     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && dst_val && dst_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h expected=none", dst_data[31:0]);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data", dst_data, e.data);
        chk("startframe", 512'(dst_startframe), 512'(e.sf));
        chk("endframe", 512'(dst_endframe), 512'(e.ef));
        chk("padbytes", 512'(dst_padbytes), 512'(e.pad));
        if (e.sf) chk("frame_size", 512'(dst_frame_size), 512'(e.size));
        out_cnt++;
      end
    end
  end

  task automatic send_beat(input logic [511:0] d, input logic last, input logic [5:0] pad);
    @(posedge clk);
    #1;
    src_val      = 1'b1;
    src_data     = d;
    src_last     = last;
    src_padbytes = pad;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    src_val  = 1'b0;
    src_last = 1'b0;
  endtask

  // Drive one frame; when keep is set, push its hand-computed expected beats.
  task automatic send_frame(input int nb, input int pad, input int size, input bit keep);
    exp_t e;
    logic [31:0] w;
    fid++;
    for (int b = 0; b < nb; b++) begin
      w      = 32'(fid * 256 + b);
      e.data = {16{w}};
      e.sf   = (b == 0);
      e.ef   = (b == nb - 1);
      e.pad  = e.ef ? 6'(pad) : 6'd0;
      e.size = 16'(size);
      if (keep) exp_q.push_back(e);
      send_beat(e.data, e.ef, e.pad);
    end
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk(name, 512'(exp_q.size()), 512'd0);
  endtask

  initial begin
    int base;
    rst          = 1'b1;
    src_val      = 1'b0;
    src_data     = 512'd0;
    src_last     = 1'b0;
    src_padbytes = 6'd0;
    dst_rdy      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dst_val", 512'(dst_val), 512'd0);
    chk("rst_startframe", 512'(dst_startframe), 512'd0);
    chk("rst_endframe", 512'(dst_endframe), 512'd0);
    chk("rst_frame_size", 512'(dst_frame_size), 512'd0);
    chk("rst_src_rdy", 512'(src_rdy), 512'd1);
`ifdef MAC_RX_PKT_QUEUE_DROP_CNT_EN
    chk("rst_drop_cnt", 512'(drop_cnt), 512'd0);
`endif
    rst = 1'b0;

    // 1-beat frame, visible the cycle after acceptance.
    dst_rdy = 1'b1;
    send_frame(1, 4, 60, 1'b1);
    idle();
    chk("one_beat_val", 512'(dst_val), 512'd1);
    chk("one_beat_sf", 512'(dst_startframe), 512'd1);
    chk("one_beat_ef", 512'(dst_endframe), 512'd1);
    chk("one_beat_size", 512'(dst_frame_size), 512'd60);
    wait_drain(20, "drain_one_beat");

    // 3-beat frame.
    send_frame(3, 10, 182, 1'b1);
    idle();
    wait_drain(20, "drain_three_beat");

    // Fill all 64 entries, then overflow with a 2-beat frame.
    dst_rdy = 1'b0;
    for (int f = 0; f < 8; f++) send_frame(8, 0, 512, 1'b1);
    send_frame(2, 0, 0, 1'b0);
    idle();
    chk("full_dst_val", 512'(dst_val), 512'd1);
`ifdef MAC_RX_PKT_QUEUE_DROP_CNT_EN
    chk("full_drop_cnt", 512'(drop_cnt), 512'd1);
`endif
    base = out_cnt;
    #1 dst_rdy = 1'b1;
    wait_drain(200, "drain_full");
    chk("full_beats_out", 512'(out_cnt - base), 512'd64);
    chk("full_empty_after", 512'(dst_val), 512'd0);

    // Oversized frame is dropped; the following frame passes.
    send_frame(70, 0, 0, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    chk("long_dst_val", 512'(dst_val), 512'd0);
`ifdef MAC_RX_PKT_QUEUE_DROP_CNT_EN
    chk("long_drop_cnt", 512'(drop_cnt), 512'd2);
`endif
    send_frame(1, 0, 64, 1'b1);
    idle();
    wait_drain(20, "drain_after_long");

    // Reset in the middle of a frame.
    send_beat({16{32'hdead0000}}, 1'b0, 6'd0);
    send_beat({16{32'hdead0001}}, 1'b0, 6'd0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_dst_val", 512'(dst_val), 512'd0);
    send_frame(1, 8, 56, 1'b1);
    idle();
    wait_drain(20, "drain_after_reset");

    // Back-to-back frames with mixed lengths and padding.
    send_frame(1, 0, 64, 1'b1);
    send_frame(1, 1, 63, 1'b1);
    send_frame(1, 63, 1, 1'b1);
    send_frame(2, 0, 128, 1'b1);
    send_frame(1, 5, 59, 1'b1);
    send_frame(3, 32, 160, 1'b1);
    send_frame(1, 17, 47, 1'b1);
    idle();
    wait_drain(50, "drain_b2b");
    chk("final_dst_val", 512'(dst_val), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_rx_pkt_queue.md
MAC_RX_PKT_QUEUE -- requirements
Module: mac_rx_pkt_queue

Interface
REQ-001 SHALL have parameters: DATA_W, default 512, beat width in bits; PADBYTES_W, default 6, log2(DATA_W/8); FRAME_SIZE_W, default 16, frame byte-count width; LOG2_ELS, default 6, log2 of beat-buffer depth.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  clock.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: src_val  in  1  input beat valid.
REQ-006 Port: src_data  in  DATA_W  input beat.
REQ-007 Port: src_last  in  1  final beat of a frame.
REQ-008 Port: src_padbytes  in  PADBYTES_W  unused trailing bytes of the last beat.
REQ-009 Port: src_rdy  out  1  always 1; the block never backpressures and drops frames on overflow.
REQ-010 Port: dst_val  out  1  output beat valid.
REQ-011 Port: dst_data  out  DATA_W  output beat.
REQ-012 Port: dst_startframe  out  1  first beat of a frame.
REQ-013 Port: dst_endframe  out  1  last beat of a frame.
REQ-014 Port: dst_padbytes  out  PADBYTES_W  padbytes stored with the beat.
REQ-015 Port: dst_frame_size  out  FRAME_SIZE_W  frame byte count; valid while dst_val and dst_startframe.
REQ-016 Port: dst_rdy  in  1  consumer accepts the beat.

Function
REQ-017 Startframe tag SHALL be 1 on the first accepted beat after reset or after a beat with src_last.
- In-frame flag set on a non-last beat; cleared on a last beat.
- A 1-beat frame carries startframe and endframe together.
REQ-018 Beat buffer SHALL be a 2^LOG2_ELS-entry circular FIFO of {data, startframe, endframe, padbytes}.
- Pointers: read, committed-write, tentative-write; wrap modulo depth.
REQ-019 Each accepted beat SHALL be written at the tentative pointer, which then increments.
REQ-020 On the endframe beat of a frame with no overflow, the committed pointer SHALL take the new tentative value and the frame size SHALL be pushed to the size FIFO.
REQ-021 Frame size SHALL be beats*(DATA_W/8) - padbytes, truncated to FRAME_SIZE_W.
REQ-022 Overflow SHALL occur when a beat arrives with all 2^LOG2_ELS entries occupied, counting uncommitted entries, or when a frame's endframe arrives with the size FIFO full.
- The frame's drop flag is set.
- The tentative pointer rewinds to the committed pointer.
- Remaining beats through endframe are discarded.
- No size is pushed.
- The next frame is accepted normally.
REQ-023 A frame longer than 2^LOG2_ELS beats SHALL always be dropped per REQ-022.
REQ-024 dst_val SHALL equal read pointer != committed pointer, so only complete frames are visible; first visibility is the cycle after the endframe beat is accepted.
REQ-025 Read path SHALL be first-word-fall-through: dst_data/tags present the head entry combinationally.
- Read pointer advances on dst_val&dst_rdy.
REQ-026 Size FIFO SHALL have 2^LOG2_ELS entries and be first-word-fall-through.
- dst_frame_size shows its head.
- Popped on dst_val&dst_rdy&dst_startframe.
REQ-027 Simultaneous write, commit and read in one cycle SHALL all take effect, with occupancy computed from pre-cycle pointers plus that cycle's read.

Reset
REQ-028 Reset SHALL clear all pointers, the in-frame flag, the drop flag and the size FIFO.
- dst_val=0, dst_startframe=0, dst_endframe=0, dst_frame_size=0.
- src_rdy=1.
REQ-029 Reset during a frame SHALL discard it, and the first beat after reset SHALL be tagged startframe.

Configuration
REQ-030 With MAC_RX_PKT_QUEUE_DROP_CNT_EN defined, SHALL add output drop_cnt (32 bits, reset 0).
- Increments once per frame dropped under REQ-022/REQ-023 and wraps at 2^32.
- Without the macro, the port and logic are absent and behaviour is otherwise identical.

Verification
REQ-031 1-beat frame, padbytes=4, dst_rdy=1 -> next cycle dst_val=1, startframe=endframe=1, frame_size=60.
REQ-032 3-beat frame, padbytes=10 -> frame_size=182; beats emitted in order with startframe on beat 0 and endframe on beat 2.
REQ-033 dst_rdy=0; write eight 8-beat frames (64 beats), then a 2-beat frame -> 2-beat frame dropped; drop_cnt=1 if enabled; then dst_rdy=1 -> exactly 64 beats out, sizes all 512.
REQ-034 70-beat frame with empty buffer -> dropped, dst_val stays 0; a following 1-beat frame is delivered.
REQ-035 Reset asserted after 2 beats of a 4-beat frame, then a new 1-beat frame -> only the new frame is delivered, tagged startframe.
REQ-036 Back-to-back 1-beat frames with dst_rdy=1 every cycle -> each delivered with the correct frame_size; the size FIFO never desynchronises from frame starts.
